// File: rtl/enc4to2_seq_if.sv
// Request/result bundle for the registered 4-to-2 encoder.
// The master drives requests and acceptance; the slave (encoder) returns codes and status.
interface enc4to2_seq_if;
    logic [3:0] req;
    logic       out_ready;
    logic       ovf_clr;
    logic       out_valid;
    logic [1:0] out_code;
    logic       busy;
    logic       ovf;

    modport master (
        output req,
        output out_ready,
        output ovf_clr,
        input  out_valid,
        input  out_code,
        input  busy,
        input  ovf
    );

    modport slave (
        input  req,
        input  out_ready,
        input  ovf_clr,
        output out_valid,
        output out_code,
        output busy,
        output ovf
    );
endinterface

// File: rtl/enc4to2_seq.sv
// Registered 4-to-2 encoder: collects request pulses into a pending set and
// emits their binary indices one per accepted cycle, fixed or rotating priority.
module enc4to2_seq #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    enc4to2_seq_if.slave bus
);

    // Output handshake: once out_valid is high, out_code is frozen until
    // out_valid & out_ready; out_valid only falls after an acceptance (or reset).
    logic [3:0] pending;
    logic       out_valid_q;
    logic [1:0] out_code_q;
    logic       ovf_q;
    logic [1:0] rr_ptr;

    logic [3:0] avail;
    logic       load;
    logic       ovf_set;
    logic [1:0] pick_idx;
    logic       pick_found;
    logic [1:0] cand;

    assign avail   = pending | bus.req;
    assign load    = !out_valid_q | bus.out_ready;
    assign ovf_set = |(bus.req & pending);

    // Scan order: 3,2,1,0 in fixed mode; rr_ptr, rr_ptr+1, ... in rotating mode.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ROUND_ROBIN ? (rr_ptr + 2'(k)) : 2'(3 - k);
            if (!pick_found && avail[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= 4'b0000;
            out_valid_q <= 1'b0;
            out_code_q  <= 2'b00;
            ovf_q       <= 1'b0;
            rr_ptr      <= 2'd0;
        end else begin
            // A fresh overflow beats a clear arriving in the same cycle.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end

            if (load) begin
                if (pick_found) begin
                    out_valid_q <= 1'b1;
                    out_code_q  <= pick_idx;
                    pending     <= avail & ~(4'b0001 << pick_idx);
                    if (ROUND_ROBIN) begin
                        rr_ptr <= pick_idx + 2'd1;
                    end
                end else begin
                    out_valid_q <= 1'b0;
                    pending     <= avail;
                end
            end else begin
                pending <= avail;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (pending != 4'b0000) | out_valid_q;

endmodule

// File: tb/tb_enc4to2_seq.sv
// Bench for enc4to2_seq: drives a fixed-priority and a round-robin instance
// with the same stimulus and compares both against a set-based reference model.
module tb_enc4to2_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic       ovf_clr;

    int n_assert = 0;
    int n_fail   = 0;

    enc4to2_seq_if f_if ();
    enc4to2_seq_if r_if ();

    assign f_if.req       = req;
    assign f_if.out_ready = out_ready;
    assign f_if.ovf_clr   = ovf_clr;
    assign r_if.req       = req;
    assign r_if.out_ready = out_ready;
    assign r_if.ovf_clr   = ovf_clr;

    enc4to2_seq #(.ROUND_ROBIN(1'b0)) dut_fix (.clk(clk), .rst_n(rst_n), .bus(f_if));
    enc4to2_seq #(.ROUND_ROBIN(1'b1)) dut_rr  (.clk(clk), .rst_n(rst_n), .bus(r_if));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: index 0 = fixed priority, index 1 = round robin
    bit m_pend  [2][4];
    bit m_valid [2];
    int m_code  [2];
    int m_ptr   [2];
    bit m_ovf   [2];

    task automatic model_step(input int m);
        bit avail [4];
        bit hit;
        int g;
        int idx;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_pend[m][i] = 1'b0;
            m_valid[m] = 1'b0;
            m_code[m]  = 0;
            m_ptr[m]   = 0;
            m_ovf[m]   = 1'b0;
            return;
        end
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            avail[i] = m_pend[m][i] || req[i];
            if (req[i] && m_pend[m][i]) hit = 1'b1;
        end
        if (hit) m_ovf[m] = 1'b1;
        else if (ovf_clr) m_ovf[m] = 1'b0;
        if (!m_valid[m] || out_ready) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m == 0) ? (3 - k) : ((m_ptr[m] + k) % 4);
                if (g < 0 && avail[idx]) g = idx;
            end
            if (g >= 0) begin
                m_valid[m] = 1'b1;
                m_code[m]  = g;
                avail[g]   = 1'b0;
                if (m == 1) m_ptr[m] = (g + 1) % 4;
            end else begin
                m_valid[m] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) m_pend[m][i] = avail[i];
    endtask

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input int m);
        logic       ov, ob, oo;
        logic [1:0] oc;
        bit         exp_busy;
        string      p;
        if (m == 0) begin
            ov = f_if.out_valid; oc = f_if.out_code; ob = f_if.busy; oo = f_if.ovf; p = "fix";
        end else begin
            ov = r_if.out_valid; oc = r_if.out_code; ob = r_if.busy; oo = r_if.ovf; p = "rr";
        end
        exp_busy = m_valid[m];
        for (int i = 0; i < 4; i++) if (m_pend[m][i]) exp_busy = 1'b1;
        check({p, "_valid"}, 32'(ov), 32'(m_valid[m]));
        check({p, "_code"},  32'(oc), 32'(m_code[m]));
        check({p, "_busy"},  32'(ob), 32'(exp_busy));
        check({p, "_ovf"},   32'(oo), 32'(m_ovf[m]));
    endtask

    // driver: one clock edge, model update, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare(0);
        compare(1);
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b0; ovf_clr = 1'b0;

        // 1: reset with requests asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            check("p1_rst_valid", 32'(f_if.out_valid), 32'd0);
            check("p1_rst_busy",  32'(f_if.busy),      32'd0);
            check("p1_rst_ovf",   32'(f_if.ovf),       32'd0);
        end
        rst_n = 1'b1; req = 4'b0000;
        tick();
        tick();
        check("p1_idle_busy", 32'(f_if.busy), 32'd0);

        // 2: single pulse
        out_ready = 1'b1; req = 4'b0100;
        tick();
        req = 4'b0000;
        check("p2_valid", 32'(f_if.out_valid), 32'd1);
        check("p2_code",  32'(f_if.out_code),  32'd2);
        tick();
        check("p2_done_valid", 32'(f_if.out_valid), 32'd0);
        check("p2_done_busy",  32'(f_if.busy),      32'd0);

        // 3: multi-hot pulse drains in priority order
        req = 4'b1011;
        tick();
        req = 4'b0000;
        check("p3_code0", 32'(f_if.out_code), 32'd3);
        tick();
        check("p3_code1", 32'(f_if.out_code), 32'd1);
        tick();
        check("p3_code2", 32'(f_if.out_code), 32'd0);
        check("p3_valid2", 32'(f_if.out_valid), 32'd1);
        tick();
        check("p3_end_valid", 32'(f_if.out_valid), 32'd0);

        // 4: backpressure holds the code
        out_ready = 1'b0; req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            req = 4'b0000;
            check("p4_hold_valid", 32'(f_if.out_valid), 32'd1);
            check("p4_hold_code",  32'(f_if.out_code),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("p4_accept_valid", 32'(f_if.out_valid), 32'd0);

        // 5: round robin with held requests, then overflow clear
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("p5_rr_code", 32'(r_if.out_code), 32'(i % 4));
            check("p5_rr_ovf",  32'(r_if.ovf),      32'(i >= 1));
        end
        req = 4'b0000; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("p5_clr_ovf_rr",  32'(r_if.ovf), 32'd0);
        check("p5_clr_ovf_fix", 32'(f_if.ovf), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("p5_drained_rr", 32'(r_if.busy), 32'd0);

        // 6: re-request of the held index is queued, not overflow
        out_ready = 1'b0; req = 4'b0010;
        tick();
        check("p6_code", 32'(f_if.out_code), 32'd1);
        tick();
        req = 4'b0000;
        check("p6_no_ovf", 32'(f_if.ovf),  32'd0);
        check("p6_busy",   32'(f_if.busy), 32'd1);
        out_ready = 1'b1;
        tick();
        check("p6_second_valid", 32'(f_if.out_valid), 32'd1);
        check("p6_second_code",  32'(f_if.out_code),  32'd1);
        tick();
        check("p6_end_busy", 32'(f_if.busy), 32'd0);

        // randomized traffic, including occasional reset mid-handshake
        for (int i = 0; i < 600; i++) begin
            req       = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            rst_n     = ($urandom_range(0, 79) != 0);
            tick();
        end
        rst_n = 1'b1; req = 4'b0000; out_ready = 1'b1; ovf_clr = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
